pe_gen2: RTL and testbench
==========================

PE_GEN2 -- requirements
Module: pe_gen2

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 16, activation and weight width.
- PSUM_WIDTH, 40, partial-sum width; must be >= 2*DATA_WIDTH.
- TAG_WIDTH, 5, weight-routing tag width.
- ROW_ID, 0, tag value this PE captures.
- SIGNED, 1, 1 = two's-complement operands and psum; 0 = unsigned.
- SATURATE, 1, 1 = clamp sum on overflow; 0 = wrap.
REQ-002 Timing SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- en_in, in, 1, activation/psum valid.
- a_in, in, DATA_WIDTH, activation.
- psum_in, in, PSUM_WIDTH, upstream partial sum.
- ovf_in, in, 1, upstream overflow flag.
- w_valid_in, in, 1, weight-chain beat valid.
- w_tag_in, in, TAG_WIDTH, weight destination row.
- w_in, in, DATA_WIDTH, weight-chain data.
- swap_in, in, 1, promote shadow weight to active.
- en_out, out, 1, registered en_in.
- a_out, out, DATA_WIDTH, forwarded activation.
- psum_out, out, PSUM_WIDTH, a*w_active + psum_in.
- ovf_out, out, 1, ovf_in OR local overflow.
- w_valid_out, out, 1, forwarded weight beat valid.
- w_tag_out, out, TAG_WIDTH, forwarded tag.
- w_out, out, DATA_WIDTH, forwarded weight data.
- swap_out, out, 1, registered swap_in.
- w_state, out, 2, {active_valid, shadow_valid}.

Function
REQ-004 All outputs SHALL be registered; latency from any input to its output SHALL be exactly 1 cycle.
REQ-005 Weight chain: w_valid_out/w_tag_out/w_out SHALL equal w_valid_in/w_tag_in/w_in delayed 1 cycle, unconditionally, including beats the PE captures.
REQ-006 Capture: when w_valid_in=1 and w_tag_in==ROW_ID, the shadow register SHALL load w_in and shadow_valid SHALL be set at the next edge; a capture while shadow_valid=1 SHALL overwrite (last write wins).
REQ-007 Swap: swap_out SHALL equal swap_in delayed 1 cycle; on swap_in=1 with shadow_valid=1, active SHALL load shadow, active_valid SHALL be set and shadow_valid cleared; with shadow_valid=0, swap SHALL have no local effect.
REQ-008 Simultaneous capture and swap: active SHALL take the old shadow value, shadow SHALL take w_in, and shadow_valid SHALL remain 1.
REQ-009 Weight state machine SHALL have 4 states encoded by w_state: EMPTY 00, SHADOW 01, ACTIVE 10, BOTH 11; transitions SHALL follow only REQ-006..008.
REQ-010 MAC: when en_in=1, a_out SHALL be a_in, en_out SHALL be 1, and psum_out SHALL be a_in*w_active+psum_in using the weight active before any same-cycle swap.
REQ-011 A swap SHALL take effect for MAC on the cycle after swap_in.
REQ-012 When en_in=1 and active_valid=0, the product SHALL be treated as 0, so psum_out=psum_in.
REQ-013 When en_in=0: en_out=0; a_out, psum_out and ovf_out SHALL hold their previous values.
REQ-014 Arithmetic: the product SHALL be full 2*DATA_WIDTH width, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to PSUM_WIDTH+1, then added to psum_in, likewise extended.
REQ-015 Overflow: ovf_out SHALL be ovf_in OR (the sum is outside the PSUM_WIDTH range); if SATURATE=1, psum_out SHALL clamp to the range max/min, else it SHALL keep the low PSUM_WIDTH bits.

Reset
REQ-016 While rst=1, all outputs, active, shadow and both valid bits SHALL be 0 asynchronously, and w_state SHALL be EMPTY.
REQ-017 Reset asserted mid-load or mid-swap SHALL discard the operation; the first edge after deassertion SHALL behave as from EMPTY.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ROW_ID=3: w_valid_in=1, tag=3, w=5 -> next cycle w_state=01 and w_out=5; tag=2 -> w_state unchanged, beat forwarded.
- Shadow=5, swap_in=1 -> next cycle w_state=10, swap_out=1; en_in=1, a=7, psum_in=100 -> psum_out=135.
- Same cycle: swap_in=1, capture w=9, en_in=1, a=2, psum_in=0 with old active=5 -> psum_out=10, w_state=11, active=5 replaced by old shadow.
- SIGNED=1, DATA_WIDTH=16, PSUM_WIDTH=32, SATURATE=1: a=-32768, w=-32768, psum_in=0x7FFFFFFF -> psum_out=0x7FFFFFFF, ovf_out=1; with SATURATE=0 -> wrapped low 32 bits, ovf_out=1.
- en_in=0 for 3 cycles after a valid MAC -> en_out=0, psum_out/a_out held; active_valid=0 with en_in=1, psum_in=42 -> psum_out=42.
- rst pulsed while w_state=11 and en_in=1 -> all outputs 0 immediately; after release, swap_in=1 -> w_state stays 00.

Source files
------------

// File: rtl/pe_gen2.sv
// ---------------------------------------------------------------------------
// pe_gen2 -- systolic-array processing element with a double-buffered weight.
//
// Each cycle the PE forwards activations and a weight-loading chain to its
// neighbours. It also accumulates a*w_active into the partial sum coming from
// upstream. New weights arrive on the chain tagged with a destination row.
// A beat whose tag matches ROW_ID is copied into a shadow register. swap_in
// promotes the shadow weight to the active slot. This lets the next weight be
// loaded while the current one is still in use.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   en_in, a_in, psum_in, ovf_in   MAC operands (valid when en_in=1)
//   w_valid_in, w_tag_in, w_in     weight-chain beat
//   swap_in                        promote shadow weight to active
//   en_out, a_out, psum_out,
//   ovf_out                        registered MAC result (held when en_in=0)
//   w_valid_out, w_tag_out, w_out  weight chain delayed one cycle
//   swap_out                       swap_in delayed one cycle
//   w_state                        {active_valid, shadow_valid}
// ---------------------------------------------------------------------------
module pe_gen2 #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 40,  // must be >= 2*DATA_WIDTH
  parameter int TAG_WIDTH  = 5,
  parameter int ROW_ID     = 0,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  ovf_in,
  input  logic                  w_valid_in,
  input  logic [TAG_WIDTH-1:0]  w_tag_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic                  swap_in,
  output logic                  en_out,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  ovf_out,
  output logic                  w_valid_out,
  output logic [TAG_WIDTH-1:0]  w_tag_out,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  swap_out,
  output logic [1:0]            w_state
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PSUM_WIDTH;

  localparam logic                 SIGNED_B   = (SIGNED != 0);
  localparam logic                 SATURATE_B = (SATURATE != 0);
  localparam logic [TAG_WIDTH-1:0] ROW_TAG    = TAG_WIDTH'(ROW_ID);

  localparam logic [PW-1:0] S_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] S_MIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0] U_MAX = {PW{1'b1}};

  // The state encoding is the w_state port value: {active_valid, shadow_valid}.
  typedef enum logic [1:0] {
    W_EMPTY  = 2'b00,
    W_SHADOW = 2'b01,
    W_ACTIVE = 2'b10,
    W_BOTH   = 2'b11
  } wstate_t;

  wstate_t           state_r;
  wstate_t           state_nxt_s;
  logic [DW-1:0]     active_w_r;
  logic [DW-1:0]     shadow_w_r;
  logic              cap_hit_s;
  logic              load_active_s;
  logic              load_shadow_s;
  logic [2*DW-1:0]   prod_s;
  logic [PW:0]       sum_s;
  logic              local_ovf_s;
  logic [PW-1:0]     result_s;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------

  // Widen an operand to 2*DW bits. The low 2*DW bits of the product of the
  // widened operands are then correct for both signed and unsigned modes.
  function automatic logic [2*DW-1:0] ext_operand(input logic [DW-1:0] v);
    return {{DW{SIGNED_B & v[DW-1]}}, v};
  endfunction

  function automatic logic [2*DW-1:0] mul_full(input logic [DW-1:0] a,
                                               input logic [DW-1:0] w);
    return ext_operand(a) * ext_operand(w);
  endfunction

  function automatic logic [PW:0] ext_prod(input logic [2*DW-1:0] p);
    return {{(PW+1-2*DW){SIGNED_B & p[2*DW-1]}}, p};
  endfunction

  function automatic logic [PW:0] ext_psum(input logic [PW-1:0] p);
    return {SIGNED_B & p[PW-1], p};
  endfunction

  // The PW+1-bit sum cannot itself overflow. The true result is out of
  // range when the two top bits disagree (signed) or the carry is set.
  function automatic logic sum_ovf(input logic [PW:0] s);
    if (SIGNED_B) begin
      return s[PW] ^ s[PW-1];
    end else begin
      return s[PW];
    end
  endfunction

  // Bound selected from the sign of the true (PW+1-bit) result.
  function automatic logic [PW-1:0] clamp_value(input logic [PW:0] s);
    if (SIGNED_B) begin
      return s[PW] ? S_MIN : S_MAX;
    end else begin
      return U_MAX;
    end
  endfunction

  assign cap_hit_s = w_valid_in && (w_tag_in == ROW_TAG);

  // ---------------------------------------------------------------------
  // Weight state machine
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= W_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A swap only acts when a shadow weight exists.
  // A capture in the same cycle refills the shadow slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      W_EMPTY: begin
        if (cap_hit_s) state_nxt_s = W_SHADOW;
        else           state_nxt_s = W_EMPTY;
      end
      W_SHADOW: begin
        if (swap_in && cap_hit_s) state_nxt_s = W_BOTH;
        else if (swap_in)         state_nxt_s = W_ACTIVE;
        else                      state_nxt_s = W_SHADOW;
      end
      W_ACTIVE: begin
        if (cap_hit_s) state_nxt_s = W_BOTH;
        else           state_nxt_s = W_ACTIVE;
      end
      W_BOTH: begin
        if (swap_in && !cap_hit_s) state_nxt_s = W_ACTIVE;
        else                       state_nxt_s = W_BOTH;
      end
      default: state_nxt_s = W_EMPTY;
    endcase
  end

  // FSM outputs: load strobes for the weight registers.
  always_comb begin
    load_shadow_s = cap_hit_s;
    load_active_s = 1'b0;
    case (state_r)
      W_SHADOW, W_BOTH: load_active_s = swap_in;
      W_EMPTY, W_ACTIVE: load_active_s = 1'b0;
      default:           load_active_s = 1'b0;
    endcase
  end

  // Weight storage. On a simultaneous swap and capture, the active slot
  // receives the old shadow value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_w_r <= {DW{1'b0}};
      shadow_w_r <= {DW{1'b0}};
    end else begin
      if (load_active_s) active_w_r <= shadow_w_r;
      else               active_w_r <= active_w_r;
      if (load_shadow_s) shadow_w_r <= w_in;
      else               shadow_w_r <= shadow_w_r;
    end
  end

  // ---------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------

  // The multiply uses the active weight held before this edge, so a swap
  // reaches the MAC one cycle later. With no active weight the product is 0.
  always_comb begin
    if (state_r[1]) prod_s = mul_full(a_in, active_w_r);
    else            prod_s = {(2*DW){1'b0}};
    sum_s       = ext_prod(prod_s) + ext_psum(psum_in);
    local_ovf_s = sum_ovf(sum_s);
    if (local_ovf_s && SATURATE_B) result_s = clamp_value(sum_s);
    else                           result_s = sum_s[PW-1:0];
  end

  // MAC output registers. When en_in=0 these hold, except en_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out   <= 1'b0;
      a_out    <= {DW{1'b0}};
      psum_out <= {PW{1'b0}};
      ovf_out  <= 1'b0;
    end else if (en_in) begin
      en_out   <= 1'b1;
      a_out    <= a_in;
      psum_out <= result_s;
      ovf_out  <= ovf_in | local_ovf_s;
    end else begin
      en_out   <= 1'b0;
      a_out    <= a_out;
      psum_out <= psum_out;
      ovf_out  <= ovf_out;
    end
  end

  // Weight chain and swap forwarding. These always forward, including beats
  // this PE captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_out <= 1'b0;
      w_tag_out   <= {TAG_WIDTH{1'b0}};
      w_out       <= {DW{1'b0}};
      swap_out    <= 1'b0;
    end else begin
      w_valid_out <= w_valid_in;
      w_tag_out   <= w_tag_in;
      w_out       <= w_in;
      swap_out    <= swap_in;
    end
  end

  assign w_state = state_r;

endmodule

// File: tb/tb_pe_gen2.sv
// ---------------------------------------------------------------------------
// tb_pe_gen2 -- self-checking bench for pe_gen2.
//
// Two instances share the same stimulus. Both use ROW_ID=3, signed 16-bit
// data and a 32-bit psum. One instance saturates and the other wraps.
// A behavioural model tracks the weights as plain variables and computes
// each MAC in 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_pe_gen2;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int TW = 5;
  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_in = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [PW-1:0] psum_in = '0;
  logic          ovf_in = 1'b0;
  logic          w_valid_in = 1'b0;
  logic [TW-1:0] w_tag_in = '0;
  logic [DW-1:0] w_in = '0;
  logic          swap_in = 1'b0;

  logic          en_s, ovf_s, wv_s, sw_s, en_w, ovf_w, wv_w, sw_w;
  logic [DW-1:0] a_s, wo_s, a_w, wo_w;
  logic [PW-1:0] ps_s, ps_w;
  logic [TW-1:0] tg_s, tg_w;
  logic [1:0]    st_s, st_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and expected outputs.
  logic [DW-1:0] m_active, m_shadow;
  logic          m_av, m_sv;
  logic          e_en, e_ovf, e_wv, e_swap;
  logic [DW-1:0] e_a, e_w;
  logic [TW-1:0] e_tag;
  logic [PW-1:0] e_sat, e_wrap;

  always #5 clk = ~clk;

  pe_gen2 #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .TAG_WIDTH(TW), .ROW_ID(3),
            .SIGNED(1), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .a_in(a_in), .psum_in(psum_in),
    .ovf_in(ovf_in), .w_valid_in(w_valid_in), .w_tag_in(w_tag_in), .w_in(w_in),
    .swap_in(swap_in), .en_out(en_s), .a_out(a_s), .psum_out(ps_s),
    .ovf_out(ovf_s), .w_valid_out(wv_s), .w_tag_out(tg_s), .w_out(wo_s),
    .swap_out(sw_s), .w_state(st_s));

  pe_gen2 #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .TAG_WIDTH(TW), .ROW_ID(3),
            .SIGNED(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en_in(en_in), .a_in(a_in), .psum_in(psum_in),
    .ovf_in(ovf_in), .w_valid_in(w_valid_in), .w_tag_in(w_tag_in), .w_in(w_in),
    .swap_in(swap_in), .en_out(en_w), .a_out(a_w), .psum_out(ps_w),
    .ovf_out(ovf_w), .w_valid_out(wv_w), .w_tag_out(tg_w), .w_out(wo_w),
    .swap_out(sw_w), .w_state(st_w));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = '0; m_shadow = '0; m_av = 1'b0; m_sv = 1'b0;
    e_en = 1'b0; e_ovf = 1'b0; e_wv = 1'b0; e_swap = 1'b0;
    e_a = '0; e_w = '0; e_tag = '0; e_sat = '0; e_wrap = '0;
  endtask

  // Apply one clock edge's worth of rules to the model.
  task automatic model_edge();
    longint p, s;
    logic   ov;
    e_wv = w_valid_in; e_tag = w_tag_in; e_w = w_in; e_swap = swap_in;
    if (en_in) begin
      p  = m_av ? longint'($signed(a_in)) * longint'($signed(m_active)) : 64'sd0;
      s  = p + longint'($signed(psum_in));
      ov = (s > PMAX) || (s < PMIN);
      e_en   = 1'b1;
      e_a    = a_in;
      e_ovf  = ovf_in | ov;
      e_wrap = s[PW-1:0];
      if (s > PMAX)      e_sat = PMAX[PW-1:0];
      else if (s < PMIN) e_sat = PMIN[PW-1:0];
      else               e_sat = s[PW-1:0];
    end else begin
      e_en = 1'b0;
    end
    if (swap_in && m_sv) begin
      m_active = m_shadow; m_av = 1'b1; m_sv = 1'b0;
    end
    if (w_valid_in && w_tag_in == 5'd3) begin
      m_shadow = w_in; m_sv = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("en_out",      en_s,  e_en);   chk("en_out_wrap",   en_w,  e_en);
    chk("a_out",       a_s,   e_a);    chk("a_out_wrap",    a_w,   e_a);
    chk("psum_sat",    ps_s,  e_sat);  chk("psum_wrap",     ps_w,  e_wrap);
    chk("ovf_out",     ovf_s, e_ovf);  chk("ovf_out_wrap",  ovf_w, e_ovf);
    chk("w_valid_out", wv_s,  e_wv);   chk("w_valid_wrap",  wv_w,  e_wv);
    chk("w_tag_out",   tg_s,  e_tag);  chk("w_tag_wrap",    tg_w,  e_tag);
    chk("w_out",       wo_s,  e_w);    chk("w_out_wrap",    wo_w,  e_w);
    chk("swap_out",    sw_s,  e_swap); chk("swap_out_wrap", sw_w,  e_swap);
    chk("w_state",     st_s,  {m_av, m_sv});
    chk("w_state_wrap", st_w, {m_av, m_sv});
  endtask

  // Inputs are driven 1 time unit after a rising edge and outputs are
  // sampled 1 time unit after the next rising edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic en, input logic [DW-1:0] a, input logic [PW-1:0] ps,
                       input logic wv, input logic [TW-1:0] tg, input logic [DW-1:0] w,
                       input logic sw);
    en_in = en; a_in = a; psum_in = ps; ovf_in = 1'b0;
    w_valid_in = wv; w_tag_in = tg; w_in = w; swap_in = sw;
  endtask

  initial begin
    // Reset state.
    model_reset();
    #2;
    check_all();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Capture tagged beat, then a non-matching beat that only forwards.
    drive(1'b0, 16'd0, 32'd0, 1'b1, 5'd3, 16'd5, 1'b0); cycle();
    chk("dir_capture_state", st_s, 2'b01); chk("dir_capture_wout", wo_s, 16'd5);
    drive(1'b0, 16'd0, 32'd0, 1'b1, 5'd2, 16'd77, 1'b0); cycle();
    chk("dir_miss_state", st_s, 2'b01); chk("dir_miss_wout", wo_s, 16'd77);

    // Swap, then MAC 7*5+100.
    drive(1'b0, 16'd0, 32'd0, 1'b0, 5'd0, 16'd0, 1'b1); cycle();
    chk("dir_swap_state", st_s, 2'b10); chk("dir_swap_out", sw_s, 1'b1);
    drive(1'b1, 16'd7, 32'd100, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
    chk("dir_mac_135", ps_s, 32'd135);

    // Load shadow=6, then swap + capture 9 + MAC in the same cycle.
    drive(1'b0, 16'd0, 32'd0, 1'b1, 5'd3, 16'd6, 1'b0); cycle();
    drive(1'b1, 16'd2, 32'd0, 1'b1, 5'd3, 16'd9, 1'b1); cycle();
    chk("dir_simul_psum", ps_s, 32'd10); chk("dir_simul_state", st_s, 2'b11);
    drive(1'b1, 16'd1, 32'd0, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
    chk("dir_new_active", ps_s, 32'd6);

    // Hold for three idle cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'hABCD, 32'hDEAD, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
      chk("dir_hold_psum", ps_s, 32'd6); chk("dir_hold_en", en_s, 1'b0);
    end

    // Overflow: active=-32768 (shadow 9 promoted first, then replaced).
    drive(1'b0, 16'd0, 32'd0, 1'b1, 5'd3, 16'h8000, 1'b1); cycle();
    drive(1'b0, 16'd0, 32'd0, 1'b0, 5'd0, 16'd0, 1'b1); cycle();
    drive(1'b1, 16'h8000, 32'h7FFFFFFF, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
    chk("dir_sat_psum", ps_s, 32'h7FFFFFFF); chk("dir_sat_ovf", ovf_s, 1'b1);
    chk("dir_wrap_psum", ps_w, 32'hBFFFFFFF); chk("dir_wrap_ovf", ovf_w, 1'b1);
    drive(1'b1, 16'h7FFF, 32'h80000000, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
    chk("dir_sat_min", ps_s, 32'h80000000);

    // Reach state 11, then pulse reset mid-cycle with a MAC pending.
    drive(1'b0, 16'd0, 32'd0, 1'b1, 5'd3, 16'd4, 1'b0); cycle();
    chk("dir_pre_rst_state", st_s, 2'b11);
    drive(1'b1, 16'd3, 32'd50, 1'b1, 5'd3, 16'd8, 1'b1);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk); rst = 1'b0;
    drive(1'b0, 16'd0, 32'd0, 1'b0, 5'd0, 16'd0, 1'b1); cycle();
    chk("dir_swap_after_rst", st_s, 2'b00);
    drive(1'b1, 16'd9, 32'd42, 1'b0, 5'd0, 16'd0, 1'b0); cycle();
    chk("dir_no_active", ps_s, 32'd42);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en_in      = ($urandom_range(3, 0) != 0);
      a_in       = DW'($urandom);
      psum_in    = ($urandom_range(7, 0) == 0) ? (($urandom_range(1, 0) != 0) ? 32'h7FFFFF00
                                                                            : 32'h80000100)
                                               : PW'($urandom);
      ovf_in     = ($urandom_range(15, 0) == 0);
      w_valid_in = ($urandom_range(1, 0) != 0);
      w_tag_in   = TW'($urandom_range(4, 0));
      w_in       = DW'($urandom);
      swap_in    = ($urandom_range(3, 0) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
